// File: rtl/seq_pkg.sv
// Shared encodings and sizing helpers for the serial sequence generator/detector family.
package seq_pkg;

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] SEND = 2'b01;
  localparam logic [1:0] GAPW = 2'b10;
  localparam logic [1:0] DONE = 2'b11;

  typedef enum logic [1:0] {
    StIdle = IDLE,
    StSend = SEND,
    StGapw = GAPW,
    StDone = DONE
  } state_e;

  // Bits needed to hold a down-counter starting at w-1.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/seq_gen_serial_tx_if.sv
// Start/ready request port and serial output stream of the pattern transmitter.
interface seq_gen_serial_tx_if #(
  parameter int unsigned W  = 8,
  parameter int unsigned RW = 4
);
  logic          start;
  logic [W-1:0]  data;
  logic [RW-1:0] rep;
  logic          ready;
  logic          x;
  logic          x_valid;
  logic          done;

  modport master (
    output start, data, rep,
    input  ready, x, x_valid, done
  );

  modport slave (
    input  start, data, rep,
    output ready, x, x_valid, done
  );
endinterface

// File: rtl/seq_gen_shreg.sv
// Loadable MSB-first shift register with a hold copy for repeat reloads.
module seq_gen_shreg #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift,
  input  logic         reload,
  input  logic [W-1:0] din,
  output logic         nxt
);

  logic [W-1:0] q_q;
  logic [W-1:0] hold_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q    <= '0;
      hold_q <= '0;
    end else if (load) begin
      q_q    <= din;
      hold_q <= din;
    end else if (reload) begin
      q_q <= hold_q;
    end else if (shift) begin
      q_q <= {q_q[W-2:0], 1'b0};
    end
  end

  // Bit that will sit at the MSB after this edge, so the caller can register it as x.
  always_comb begin
    nxt = q_q[W-1];
    if (load) begin
      nxt = din[W-1];
    end else if (reload) begin
      nxt = hold_q[W-1];
    end else if (shift) begin
      nxt = q_q[W-2];
    end
  end

endmodule

// File: rtl/seq_gen_serial_tx.sv
// Serial pattern transmitter: sends a W-bit word MSB-first rep+1 times with optional idle gaps.
module seq_gen_serial_tx
  import seq_pkg::*;
#(
  parameter int unsigned W   = 8,
  parameter int unsigned RW  = 4,
  parameter int unsigned GAP = 0
) (
  input logic               clk,
  input logic               rst,
  seq_gen_serial_tx_if.slave bus
);

  localparam int unsigned BW = cnt_width(W);
  localparam int unsigned GW = (GAP > 1) ? $clog2(GAP) : 1;

  state_e        state_q;
  logic [BW-1:0] bit_cnt_q;
  logic [RW-1:0] rep_cnt_q;
  logic [GW-1:0] gap_cnt_q;
  logic          ready_q;
  logic          x_q;
  logic          x_valid_q;
  logic          done_q;

  logic sh_load;
  logic sh_shift;
  logic sh_reload;
  logic sh_nxt;
  logic last_bit;

  always_comb begin
    last_bit  = (state_q == StSend) && (bit_cnt_q == '0);
    sh_load   = (state_q == StIdle) && bus.start;
    sh_shift  = (state_q == StSend) && !last_bit;
    sh_reload = last_bit && (rep_cnt_q != '0);
  end

  seq_gen_shreg #(
    .W(W)
  ) u_shreg (
    .clk   (clk),
    .rst   (rst),
    .load  (sh_load),
    .shift (sh_shift),
    .reload(sh_reload),
    .din   (bus.data),
    .nxt   (sh_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      rep_cnt_q <= '0;
      gap_cnt_q <= '0;
      ready_q   <= 1'b1;
      x_q       <= 1'b0;
      x_valid_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            state_q   <= StSend;
            bit_cnt_q <= BW'(W - 1);
            rep_cnt_q <= bus.rep;
            ready_q   <= 1'b0;
            x_q       <= sh_nxt;
            x_valid_q <= 1'b1;
          end
        end
        StSend: begin
          if (bit_cnt_q != '0) begin
            bit_cnt_q <= bit_cnt_q - 1'b1;
            x_q       <= sh_nxt;
          end else if (rep_cnt_q == '0) begin
            state_q   <= StDone;
            x_q       <= 1'b0;
            x_valid_q <= 1'b0;
            done_q    <= 1'b1;
          end else begin
            rep_cnt_q <= rep_cnt_q - 1'b1;
            bit_cnt_q <= BW'(W - 1);
            if (GAP > 0) begin
              state_q   <= StGapw;
              gap_cnt_q <= GW'(GAP - 1);
              x_q       <= 1'b0;
              x_valid_q <= 1'b0;
            end else begin
              // Back-to-back: next repetition's MSB follows with no bubble.
              x_q <= sh_nxt;
            end
          end
        end
        StGapw: begin
          if (gap_cnt_q == '0) begin
            state_q   <= StSend;
            x_q       <= sh_nxt;
            x_valid_q <= 1'b1;
          end else begin
            gap_cnt_q <= gap_cnt_q - 1'b1;
          end
        end
        StDone: begin
          state_q <= StIdle;
          ready_q <= 1'b1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.ready   = ready_q;
  assign bus.x       = x_q;
  assign bus.x_valid = x_valid_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_seq_gen_serial_tx.sv
// Directed bench: per-cycle expected {ready, x_valid, x, done} queued at request time.
module tb_seq_gen_serial_tx;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seq_gen_serial_tx_if #(.W(8), .RW(4)) b0 ();
  seq_gen_serial_tx_if #(.W(8), .RW(4)) b2 ();

  seq_gen_serial_tx #(.W(8), .RW(4), .GAP(0)) dut0 (
    .clk(clk),
    .rst(rst),
    .bus(b0)
  );

  seq_gen_serial_tx #(.W(8), .RW(4), .GAP(2)) dut2 (
    .clk(clk),
    .rst(rst),
    .bus(b2)
  );

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] outs(input int sel);
    if (sel == 0) return {b0.ready, b0.x_valid, b0.x, b0.done};
    return {b2.ready, b2.x_valid, b2.x, b2.done};
  endfunction

  task automatic drive(input int sel, input logic s, input logic [7:0] d, input logic [3:0] r);
    if (sel == 0) begin
      b0.start = s;
      b0.data  = d;
      b0.rep   = r;
    end else begin
      b2.start = s;
      b2.data  = d;
      b2.rep   = r;
    end
  endtask

  // Called at a negedge while the DUT is idle; returns at the negedge of the first ready cycle.
  task automatic send(input int sel, input logic [7:0] d, input logic [3:0] r, input int gap,
                      input bit hold, input bit chk_y, input logic [7:0] exp_y,
                      input string tag);
    int busy = 0;
    int dones = 0;
    int ones = 0;
    int nb = 0;
    int cyc = 1;
    logic [7:0] ymask = '0;
    logic [3:0] o;
    logic [3:0] e;
    for (int i = 0; i <= int'(r); i++) begin
      for (int b = 7; b >= 0; b--) exp_q.push_back({1'b0, 1'b1, d[b], 1'b0});
      if (i < int'(r)) for (int g = 0; g < gap; g++) exp_q.push_back(4'b0000);
    end
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b1000);
    drive(sel, 1'b1, d, r);
    @(negedge clk);
    // Inputs change while busy; they must have no effect.
    drive(sel, hold, ~d, ~r);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = outs(sel);
      chk($sformatf("%s cyc%0d", tag, cyc), 32'(o), 32'(e));
      if (!o[3]) busy++;
      if (o[0]) dones++;
      if (o[2] && nb < 8) begin
        // Non-overlapping 111 detector fed from the serial line.
        if (o[1] && ones == 2) begin
          ymask[nb] = 1'b1;
          ones = 0;
        end else begin
          ones = o[1] ? ones + 1 : 0;
        end
        nb++;
      end
      cyc++;
      if (exp_q.size() > 0) @(negedge clk);
    end
    chk({tag, " busy"}, 32'(busy), 32'((int'(r) + 1) * 8 + int'(r) * gap + 1));
    chk({tag, " dones"}, 32'(dones), 32'd1);
    if (chk_y) chk({tag, " y"}, 32'(ymask), 32'(exp_y));
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 1'b1, 8'h55, 4'h0);
    drive(2, 1'b1, 8'h55, 4'h0);
    repeat (3) @(negedge clk);
    chk("reset dut0", 32'(outs(0)), 32'h8);
    chk("reset dut2", 32'(outs(2)), 32'h8);
    rst = 1'b0;
    drive(0, 1'b0, 8'h00, 4'h0);
    drive(2, 1'b0, 8'h00, 4'h0);
    @(negedge clk);
    chk("idle dut0", 32'(outs(0)), 32'h8);
    chk("idle dut2", 32'(outs(2)), 32'h8);

    send(0, 8'hE7, 4'h0, 0, 1'b0, 1'b0, 8'h00, "e7");
    send(2, 8'hA5, 4'h1, 2, 1'b0, 1'b0, 8'h00, "a5_gap2");
    send(0, 8'hFF, 4'h0, 0, 1'b0, 1'b1, 8'b0010_0100, "ff_loop");
    send(0, 8'h3C, 4'h2, 0, 1'b1, 1'b0, 8'h00, "held");
    send(0, 8'h96, 4'h0, 0, 1'b0, 1'b0, 8'h00, "reaccept");

    // Abort on the 4th bit of F0.
    drive(0, 1'b1, 8'hF0, 4'h0);
    @(negedge clk);
    drive(0, 1'b0, 8'hF0, 4'h0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("abort bit%0d", i), 32'(outs(0)), 32'h6);
      if (i < 3) @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort reset", 32'(outs(0)), 32'h8);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("abort idle%0d", i), 32'(outs(0)), 32'h8);
    end
    send(0, 8'h0F, 4'h0, 0, 1'b0, 1'b0, 8'h00, "0f_after_abort");

    send(0, 8'hC3, 4'hF, 0, 1'b0, 1'b0, 8'h00, "rep_max");
    send(2, 8'h81, 4'h0, 2, 1'b0, 1'b0, 8'h00, "gap2_rep0");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
